lcd_text_driver: RTL and testbench

Downstream consumer of the display-mode text sources (stopwatch, clock, alarm screens) that present one ASCII character per 5-bit screen index with one registered cycle of latency. It initialises an HD44780-compatible 16x2 character LCD in 8-bit write-only mode. It then refreshes both lines continuously by sweeping `index` 0..31, capturing each returned character and strobing it into the panel with parameterised enable and settle timing.

---
 rtl/lcd_text_driver.sv | 231 +++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 driver: 8-bit write-only init, then continuous refresh of 32 characters
// fetched from an indexed text source. Define LCD_FRAME_GAP_EN to idle between frames.
module lcd_text_driver #(
  parameter int unsigned INIT_WAIT_CYC  = 750000,
  parameter int unsigned E_PULSE_CYC    = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000,
  parameter int unsigned FRAME_GAP_CYC  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  output logic [4:0] index,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       frame_done
);

`ifdef LCD_FRAME_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [19:0] INIT_LD  = 20'(INIT_WAIT_CYC);
  localparam logic [19:0] E_LD     = 20'(E_PULSE_CYC);
  localparam logic [19:0] CMD_LD   = 20'(CMD_WAIT_CYC);
  localparam logic [19:0] CLEAR_LD = 20'(CLEAR_WAIT_CYC);
  localparam logic [19:0] GAP_LD   = 20'(FRAME_GAP_CYC);

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT_CMD,
    S_LINE_ADDR,
    S_FETCH0,
    S_FETCH1,
    S_SETUP,
    S_STROBE,
    S_SETTLE,
    S_GAP
  } state_t;

  // What the current strobe carries, so SETTLE knows where to go next.
  typedef enum logic [1:0] {
    K_INIT,
    K_ADDR,
    K_CHAR
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  step_q, step_d;
  logic [4:0]  index_q, index_d;
  logic        lcd_e_q, lcd_e_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        init_done_q, init_done_d;
  logic        frame_done_q, frame_done_d;
  logic        cnt_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    case (step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign cnt_last = (cnt_q == 20'd1);

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    cnt_d        = cnt_q;
    step_d       = step_q;
    index_d      = index_q;
    lcd_rs_d     = lcd_rs_q;
    lcd_data_d   = lcd_data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_last) begin
          state_d    = S_INIT_CMD;
          kind_d     = K_INIT;
          lcd_rs_d   = 1'b0;
          lcd_data_d = init_cmd(step_q);
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      // Setup cycles: bus already driven on entry, strobe follows.
      S_INIT_CMD, S_LINE_ADDR, S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = E_LD;
      end

      S_STROBE: begin
        if (cnt_last) begin
          state_d = S_SETTLE;
          cnt_d   = (kind_q == K_INIT && step_q == 2'd3) ? CLEAR_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      S_SETTLE: begin
        if (!cnt_last) begin
          cnt_d = cnt_q - 20'd1;
        end else begin
          case (kind_q)
            K_INIT: begin
              if (step_q == 2'd3) begin
                init_done_d = 1'b1;
                state_d     = S_LINE_ADDR;
                kind_d      = K_ADDR;
                lcd_rs_d    = 1'b0;
                lcd_data_d  = 8'h80;
              end else begin
                step_d     = step_q + 2'd1;
                state_d    = S_INIT_CMD;
                lcd_rs_d   = 1'b0;
                lcd_data_d = init_cmd(step_q + 2'd1);
              end
            end
            K_ADDR: begin
              // index still shows the last character of line 1 when the C0 address was sent
              state_d = S_FETCH0;
              index_d = (index_q == 5'd15) ? 5'd16 : 5'd0;
            end
            default: begin
              if (index_q == 5'd31) begin
                frame_done_d = 1'b1;
                index_d      = 5'd0;
                if (GAP_EN) begin
                  state_d = S_GAP;
                  cnt_d   = GAP_LD;
                end else begin
                  state_d    = S_LINE_ADDR;
                  kind_d     = K_ADDR;
                  lcd_rs_d   = 1'b0;
                  lcd_data_d = 8'h80;
                end
              end else if (index_q == 5'd15) begin
                state_d    = S_LINE_ADDR;
                kind_d     = K_ADDR;
                lcd_rs_d   = 1'b0;
                lcd_data_d = 8'hC0;
              end else begin
                state_d = S_FETCH0;
                index_d = index_q + 5'd1;
              end
            end
          endcase
        end
      end

      S_FETCH0: begin
        state_d = S_FETCH1;
      end

      // Source has had its registered cycle; capture the character now.
      S_FETCH1: begin
        state_d    = S_SETUP;
        kind_d     = K_CHAR;
        lcd_rs_d   = 1'b1;
        lcd_data_d = char_in;
      end

      S_GAP: begin
        if (cnt_last) begin
          state_d    = S_LINE_ADDR;
          kind_d     = K_ADDR;
          lcd_rs_d   = 1'b0;
          lcd_data_d = 8'h80;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end

      default: begin
        state_d = S_PWR_WAIT;
        cnt_d   = INIT_LD;
      end
    endcase

    lcd_e_d = (state_d == S_STROBE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PWR_WAIT;
      kind_q       <= K_INIT;
      cnt_q        <= INIT_LD;
      step_q       <= 2'd0;
      index_q      <= 5'd0;
      lcd_e_q      <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      index_q      <= index_d;
      lcd_e_q      <= lcd_e_d;
      lcd_rs_q     <= lcd_rs_d;
      lcd_data_q   <= lcd_data_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign index      = index_q;
  assign lcd_e      = lcd_e_q;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = lcd_data_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: random screen contents from a 1-cycle source model, checked
// against the expected strobe sequence, strobe timing, frame_done and init_done behaviour.
module tb_lcd_text_driver;

  localparam int P_INIT  = 10;
  localparam int P_E     = 2;
  localparam int P_W     = 4;
  localparam int P_CLEAR = 8;
  localparam int P_GAP   = 6;
`ifdef LCD_FRAME_GAP_EN
  localparam int GAP_EXP = P_GAP;
`else
  localparam int GAP_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic [4:0] index;
  logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0] lcd_data;

  lcd_text_driver #(
    .INIT_WAIT_CYC (P_INIT),
    .E_PULSE_CYC   (P_E),
    .CMD_WAIT_CYC  (P_W),
    .CLEAR_WAIT_CYC(P_CLEAR),
    .FRAME_GAP_CYC (P_GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .index     (index),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Text source: screen memory read with one registered cycle of latency.
  logic [7:0] mem[32];
  logic [7:0] snap[32];
  always @(posedge clk) char_in <= mem[index];

  logic rst_s = 1'b1;
  always @(posedge clk) rst_s <= rst;

  // Expected-sequence monitor: strobe n since reset is init cmd (n<4) or position
  // (n-4)%34 of a frame laid out as 80, chars 0..15, C0, chars 16..31.
  int         since_rel, nstr, lowrun, highrun, fd_count, last_m;
  logic       e_prev, fd_prev, rise_rs;
  logic [7:0] rise_data;

  always @(negedge clk) begin
    if (rst_s) begin
      check("rst_e", 32'(lcd_e), 0);
      check("rst_rs", 32'(lcd_rs), 0);
      check("rst_data", 32'(lcd_data), 0);
      check("rst_index", 32'(index), 0);
      check("rst_init_done", 32'(init_done), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      since_rel = 0; nstr = 0; lowrun = 0; highrun = 0; fd_count = 0; last_m = -1;
      e_prev = 1'b0; fd_prev = 1'b0;
    end else begin
      since_rel++;
      if (since_rel == P_INIT - 1) begin
        check("pwr_data", 32'(lcd_data), 0);
        check("pwr_init_done", 32'(init_done), 0);
      end
      if (lcd_e) begin
        if (!e_prev) begin : on_rise
          int m, k, exp_low;
          logic erd;
          logic [7:0] ed;
          m = -1; k = -1; erd = 1'b0; ed = 8'h00;
          if (nstr < 4) begin
            case (nstr)
              0: ed = 8'h38;
              1: ed = 8'h0C;
              2: ed = 8'h06;
              default: ed = 8'h01;
            endcase
          end else begin
            m = (nstr - 4) % 34;
            if (m == 0) begin
              ed = 8'h80;
              snap = mem;
              check("fd_count", 32'(fd_count), 32'((nstr - 4) / 34));
              check("idx_80", 32'(index), 0);
            end else if (m == 17) begin
              ed = 8'hC0;
              check("idx_c0", 32'(index), 15);
            end else begin
              k = (m < 17) ? m - 1 : m - 2;
              erd = 1'b1;
              ed = snap[k];
              check("index", 32'(index), 32'(k));
            end
            check("init_done_hi", 32'(init_done), 1);
          end
          if (nstr == 0) begin
            check("first_e", 32'(since_rel), 32'(P_INIT + 1));
          end else begin
            exp_low = ((nstr == 4) ? P_CLEAR : P_W) + ((k >= 0) ? 3 : 1)
                      + ((m == 0 && nstr > 4) ? GAP_EXP : 0);
            check("low_run", 32'(lowrun), 32'(exp_low));
          end
          check("rs", 32'(lcd_rs), 32'(erd));
          check("data", 32'(lcd_data), 32'(ed));
          check("rw", 32'(lcd_rw), 0);
          $display("strobe n=%0d rs=%0d data=%02h index=%0d", nstr, lcd_rs, lcd_data, index);
          rise_rs = lcd_rs; rise_data = lcd_data; last_m = m; nstr++;
          highrun = 0; lowrun = 0;
        end
        highrun++;
      end else begin
        if (e_prev) begin
          check("e_width", 32'(highrun), 32'(P_E));
          check("hold", 32'({lcd_rs, lcd_data}), 32'({rise_rs, rise_data}));
        end
        lowrun++;
        if (nstr == 4) check("init_done", 32'(init_done), 32'(lowrun >= P_CLEAR + 1));
      end
      if (frame_done) begin
        fd_count++;
        check("fd_after31", 32'(last_m), 33);
        check("fd_index", 32'(index), 0);
        check("fd_single", 32'(fd_prev), 0);
        check("fd_lowrun", 32'(lowrun), 32'(P_W + 1));
`ifdef LCD_FRAME_GAP_EN
        check("fd_held", 32'({lcd_rs, lcd_data}), 32'({rise_rs, rise_data}));
`else
        check("fd_addr", 32'({lcd_rs, lcd_data}), 32'({1'b0, 8'h80}));
`endif
      end
      e_prev = lcd_e;
      fd_prev = frame_done;
    end
  end

  task automatic wait_index(input logic [4:0] p);
    int t = 0;
    do begin @(negedge clk); t++; end while (index != p && t < 4000);
    check("to_index", 32'(index), 32'(p));
  endtask

  task automatic wait_fd();
    int t = 0;
    do begin @(negedge clk); t++; end while (!frame_done && t < 4000);
    check("to_frame_done", 32'(frame_done), 1);
  endtask

  task automatic wait_e();
    int t = 0;
    do begin @(negedge clk); t++; end while (!lcd_e && t < 4000);
    check("to_lcd_e", 32'(lcd_e), 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h41 + i);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Frame 0 shows 'A'.. unchanged; index 5 rewritten while 20 is on the bus.
    // Later frames rewrite random already-written positions.
    for (int it = 0; it < 4; it++) begin
      int p;
      p = (it == 0) ? 20 : int'($urandom_range(1, 31));
      wait_index(5'(p));
      if (it == 0) begin
        mem[5] = 8'($urandom_range(128, 255));
      end else begin
        for (int j = 0; j < p; j++)
          if ($urandom_range(0, 1) == 1) mem[j] = 8'($urandom);
      end
      wait_fd();
    end

    // Reset in the middle of an enable pulse.
    repeat (int'($urandom_range(0, 40))) @(negedge clk);
    wait_e();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_fd();
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
